// File: rtl/puf_pkg.sv
// Shared types and default sizing for the PUF ring-oscillator measurement path.
// Pure declarations; no logic, no latency, no flow control.
package puf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COUNT  = 2'd2,
        DONE   = 2'd3
    } ro_cnt_state_t;

    localparam int RO_CNT_W       = 16;
    localparam int RO_WINDOW      = 1024;
    localparam int RO_SETTLE_CYC  = 16;
    localparam int RO_SYNC_STAGES = 2;

    // One timer is shared by SETTLE and COUNT, so it must hold the larger reload.
    function automatic int ro_timer_width(input int window, input int settle);
        int m;
        m = (window > settle) ? window : settle;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/ro_pair_counter_if.sv
// Control/result bundle between the RO pair counter and the response collector.
// Plain wires; start is a level request, done is a one-cycle result strobe.
interface ro_pair_counter_if #(
    parameter int CNT_W = puf_pkg::RO_CNT_W
);

    logic             start;
    logic             busy;
    logic             done;
    logic             response;
    logic             tie;
    logic [CNT_W-1:0] count_a;
    logic [CNT_W-1:0] count_b;

    modport master (
        output start,
        input  busy,
        input  done,
        input  response,
        input  tie,
        input  count_a,
        input  count_b
    );

    modport slave (
        input  start,
        output busy,
        output done,
        output response,
        output tie,
        output count_a,
        output count_b
    );

endinterface

// File: rtl/ro_edge_sync.sv
// Synchronizes one free-running ring-oscillator output into core_clk and flags rising edges.
// Latency SYNC_STAGES cycles to sync_now, rise_pulse combinational from flops; no backpressure.
module ro_edge_sync
    import puf_pkg::*;
#(
    parameter int SYNC_STAGES = RO_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("ro_edge_sync needs at least two synchronizer stages");
    end

    // History runs in every state so enable-induced edges age out before counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/ro_pair_counter.sv
// Enables one RO pair, settles, counts both oscillators over a fixed window, emits one response bit.
// done fires 1+SETTLE_CYC+WINDOW cycles after start is sampled; start is ignored while busy.
module ro_pair_counter
    import puf_pkg::*;
#(
    parameter int CNT_W       = RO_CNT_W,
    parameter int WINDOW      = RO_WINDOW,
    parameter int SETTLE_CYC  = RO_SETTLE_CYC,
    parameter int SYNC_STAGES = RO_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro_a,
    input  logic             ro_b,
    output logic             en_a,
    output logic             en_b,
    ro_pair_counter_if.slave ctl
);

    localparam int               TMR_W       = ro_timer_width(WINDOW, SETTLE_CYC);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] WINDOW_LOAD = TMR_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    if (WINDOW < 1) begin : g_bad_window
        $error("ro_pair_counter WINDOW must be at least 1");
    end
    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("ro_pair_counter SETTLE_CYC must be at least 1");
    end

    ro_cnt_state_t    state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
    logic             response_q, response_d;
    logic             tie_q, tie_d;
    logic             rise_a;
    logic             rise_b;
    logic             running;

    ro_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (ro_a),
        .rise_pulse (rise_a)
    );

    ro_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (ro_b),
        .rise_pulse (rise_b)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;
        response_d = response_q;
        tie_d      = tie_q;

        case (state_q)
            IDLE: begin
                if (ctl.start) begin
                    state_d = SETTLE;
                    timer_d = SETTLE_LOAD;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                end
            end
            SETTLE: begin
                if (timer_q == '0) begin
                    state_d = COUNT;
                    timer_d = WINDOW_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            COUNT: begin
                if (rise_a && (cnt_a_q != CNT_MAX)) begin
                    cnt_a_d = cnt_a_q + 1'b1;
                end
                if (rise_b && (cnt_b_q != CNT_MAX)) begin
                    cnt_b_d = cnt_b_q + 1'b1;
                end
                // Compare the post-increment values so the last window cycle still counts.
                if (timer_q == '0) begin
                    state_d    = DONE;
                    response_d = (cnt_a_d > cnt_b_d);
                    tie_d      = (cnt_a_d == cnt_b_d);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            response_q <= 1'b0;
            tie_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            response_q <= response_d;
            tie_q      <= tie_d;
        end
    end

    assign running      = (state_q == SETTLE) || (state_q == COUNT);
    assign en_a         = running;
    assign en_b         = running;
    assign ctl.busy     = running;
    assign ctl.done     = (state_q == DONE);
    assign ctl.response = response_q;
    assign ctl.tie      = tie_q;
    assign ctl.count_a  = cnt_a_q;
    assign ctl.count_b  = cnt_b_q;

endmodule

// File: tb/tb_ro_pair_counter.sv
// Randomized bench for ro_pair_counter: a wide and a 3-bit-saturating instance share stimulus
// and are checked every cycle against an edge-history model of the window.
module tb_ro_pair_counter;

    localparam int W    = 96;
    localparam int S    = 4;
    localparam int SYNC = 2;
    localparam int CW   = 16;
    localparam int CWS  = 3;
    localparam int NSMP = 40000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic ro_a  = 1'b0;
    logic ro_b  = 1'b0;
    logic en_a, en_b, en_a_s, en_b_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ro_pair_counter_if #(.CNT_W(CW))  bus   ();
    ro_pair_counter_if #(.CNT_W(CWS)) bus_s ();
    assign bus.start   = start;
    assign bus_s.start = start;

    ro_pair_counter #(.CNT_W(CW), .WINDOW(W), .SETTLE_CYC(S), .SYNC_STAGES(SYNC)) dut (
        .clk (clk), .rst_n (rst_n), .ro_a (ro_a), .ro_b (ro_b),
        .en_a (en_a), .en_b (en_b), .ctl (bus)
    );

    ro_pair_counter #(.CNT_W(CWS), .WINDOW(W), .SETTLE_CYC(S), .SYNC_STAGES(SYNC)) dut_s (
        .clk (clk), .rst_n (rst_n), .ro_a (ro_a), .ro_b (ro_b),
        .en_a (en_a_s), .en_b (en_b_s), .ctl (bus_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        total++;
        if (act !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Oscillator stimulus: square waves with programmable period/high time, or random toggling.
    int pa = 8, ha = 4, pb = 12, hb = 6, pha = 0, phb = 0;
    bit rnd_mode = 1'b0;

    task automatic set_ro(input int a_per, input int a_hi, input int b_per, input int b_hi, input bit rnd);
        pa = a_per; ha = a_hi; pb = b_per; hb = b_hi; rnd_mode = rnd;
        pha = $urandom_range(0, a_per - 1);
        phb = $urandom_range(0, b_per - 1);
    endtask

    initial forever begin
        @(negedge clk);
        if (rnd_mode) begin
            if ($urandom_range(0, 2) == 0) ro_a = ~ro_a;
            if ($urandom_range(0, 2) == 0) ro_b = ~ro_b;
        end else begin
            pha  = (pha + 1) % pa;
            phb  = (phb + 1) % pb;
            ro_a = (pha < ha);
            ro_b = (phb < hb);
        end
    end

    // Model: record what each synchronizer input saw at every clock edge.
    int n = 0;
    bit smpa [NSMP];
    bit smpb [NSMP];
    int m_s = 0;
    bit m_active = 1'b0;
    int free_edge = 0;
    bit has_res = 1'b0;
    int last_a = 0, last_b = 0;

    always @(posedge clk) begin
        n = n + 1;
        if (n < NSMP) begin
            smpa[n] = rst_n & ro_a;
            smpb[n] = rst_n & ro_b;
        end
        if (rst_n && start && n >= free_edge) begin
            m_s       = n;
            m_active  = 1'b1;
            free_edge = n + S + W + 2;
        end
    end

    always @(negedge rst_n) begin
        m_active = 1'b0; has_res = 1'b0; last_a = 0; last_b = 0; free_edge = 0;
    end

    function automatic int smp(input int ch, input int i);
        if (i < 1 || i >= NSMP) return 0;
        return (ch == 0) ? int'(smpa[i]) : int'(smpb[i]);
    endfunction

    // Rising edges visible after the synchronizer during the cycles following edges lo..hi.
    function automatic int rises(input int ch, input int lo, input int hi);
        int c = 0;
        for (int m = lo; m <= hi; m++)
            if (smp(ch, m - SYNC + 1) == 1 && smp(ch, m - SYNC) == 0) c++;
        return c;
    endfunction

    function automatic int sat(input int v, input int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check_inst(input string tag, input int cw,
                              input logic bz, input logic ea, input logic eb, input logic dn,
                              input logic rs, input logic ti,
                              input logic [31:0] ca, input logic [31:0] cb,
                              input bit x_busy, input bit x_done, input int x_ca, input int x_cb,
                              input bit x_hr, input int x_ra, input int x_rb);
        int sa, sb;
        sa = sat(x_ra, cw);
        sb = sat(x_rb, cw);
        chk({tag, ".busy"},     bz, int'(x_busy));
        chk({tag, ".en_a"},     ea, int'(x_busy));
        chk({tag, ".en_b"},     eb, int'(x_busy));
        chk({tag, ".done"},     dn, int'(x_done));
        chk({tag, ".count_a"},  ca, sat(x_ca, cw));
        chk({tag, ".count_b"},  cb, sat(x_cb, cw));
        chk({tag, ".response"}, rs, x_hr ? int'(sa > sb) : 0);
        chk({tag, ".tie"},      ti, x_hr ? int'(sa == sb) : 0);
    endtask

    always @(negedge clk) begin : cmp
        bit x_busy, x_done, x_hr;
        int x_ca, x_cb, x_ra, x_rb, hi;
        x_busy = 1'b0; x_done = 1'b0; x_hr = has_res;
        x_ca = last_a; x_cb = last_b; x_ra = last_a; x_rb = last_b;
        if (m_active) begin
            x_busy = (n < m_s + S + W);
            x_done = (n == m_s + S + W);
            hi     = (n - 1 < m_s + S + W - 1) ? n - 1 : m_s + S + W - 1;
            x_ca   = rises(0, m_s + S, hi);
            x_cb   = rises(1, m_s + S, hi);
            if (x_done) begin
                x_hr = 1'b1; x_ra = x_ca; x_rb = x_cb;
            end
        end
        check_inst("main", CW, bus.busy, en_a, en_b, bus.done, bus.response, bus.tie,
                   32'(bus.count_a), 32'(bus.count_b), x_busy, x_done, x_ca, x_cb, x_hr, x_ra, x_rb);
        check_inst("sat", CWS, bus_s.busy, en_a_s, en_b_s, bus_s.done, bus_s.response, bus_s.tie,
                   32'(bus_s.count_a), 32'(bus_s.count_b), x_busy, x_done, x_ca, x_cb, x_hr, x_ra, x_rb);
        if (x_done) begin
            last_a = x_ca; last_b = x_cb; has_res = 1'b1; m_active = 1'b0;
        end
    end

    // One measurement; x1/x2 are extra start pulses (k index) that must be ignored.
    task automatic measure(input int x1, input int x2);
        int kd, en_cnt, dn_cnt;
        kd = 0; en_cnt = 0; dn_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (en_a && en_b) en_cnt++;
            if (bus.done) begin
                dn_cnt++;
                if (kd == 0) kd = k;
                chk("en_off_in_done", {en_a, en_b}, 0);
            end
            start = (k == x1 || k == x2);
            if (kd != 0 && k >= kd + 5) break;
        end
        start = 1'b0;
        if (kd == 0) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done want done within 300 cycles");
        end
        chk("done_latency", kd, S + W + 1);
        chk("en_cycles", en_cnt, S + W);
        chk("done_pulses", dn_cnt, 1);
    endtask

    initial begin
        int d1, d2, d3, dn_cnt;
        set_ro(8, 4, 12, 6, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_en_a", en_a, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_count_a", bus.count_a, 0);
        chk("rst_tie", bus.tie, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Basic compare: 96-cycle window, periods 8 and 12.
        measure(0, 0);
        chk("basic_count_a", bus.count_a, 12);
        chk("basic_count_b", bus.count_b, 8);
        chk("basic_response", bus.response, 1);
        chk("basic_tie", bus.tie, 0);
        chk("basic_sat_count_a", bus_s.count_a, 7);
        chk("basic_sat_tie", bus_s.tie, 1);
        chk("model_pin_a", rises(0, m_s + S, m_s + S + W - 1), 12);
        chk("model_pin_b", rises(1, m_s + S, m_s + S + W - 1), 8);

        // Start pulses during SETTLE and COUNT are ignored.
        measure(2, 50);
        chk("ignored_count_a", bus.count_a, 12);

        // Async reset in the middle of COUNT.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_en_a", en_a, 0);
        chk("midrst_en_b", en_b, 0);
        chk("midrst_count_a", bus.count_a, 0);
        chk("midrst_response", bus.response, 0);
        chk("midrst_sat_count_a", bus_s.count_a, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dn_cnt = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (bus.done) dn_cnt++;
        end
        chk("midrst_no_done", dn_cnt, 0);
        measure(0, 0);
        chk("fresh_count_a", bus.count_a, 12);
        chk("fresh_count_b", bus.count_b, 8);

        // Swap and tie.
        set_ro(12, 6, 8, 4, 1'b0);
        measure(0, 0);
        chk("swap_response", bus.response, 0);
        chk("swap_tie", bus.tie, 0);
        set_ro(8, 3, 8, 5, 1'b0);
        measure(0, 0);
        chk("tie_count_a", bus.count_a, 12);
        chk("tie_count_b", bus.count_b, 12);
        chk("tie_tie", bus.tie, 1);
        chk("tie_response", bus.response, 0);

        // Saturation on the 3-bit instance.
        set_ro(4, 2, 16, 8, 1'b0);
        measure(0, 0);
        chk("sat_count_a", bus_s.count_a, 7);
        chk("sat_count_b", bus_s.count_b, 6);
        chk("sat_response", bus_s.response, 1);
        chk("wide_count_a", bus.count_a, 24);

        // Continuous start: back-to-back with one IDLE cycle between.
        set_ro(8, 4, 12, 6, 1'b0);
        d1 = 0; d2 = 0; d3 = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (bus.done) begin
                chk("cont_count_a", bus.count_a, 12);
                chk("cont_count_b", bus.count_b, 8);
                if (d1 == 0) d1 = k;
                else if (d2 == 0) d2 = k;
                else begin
                    d3 = k;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        chk("cont_first", d1, S + W + 1);
        chk("cont_gap1", d2 - d1, S + W + 2);
        chk("cont_gap2", d3 - d2, S + W + 2);
        repeat (3) @(negedge clk);

        // Randomized oscillator shapes, gaps and ignored start pulses.
        for (int it = 0; it < 25; it++) begin
            int a_per, b_per;
            a_per = $urandom_range(2, 24);
            b_per = $urandom_range(2, 24);
            set_ro(a_per, $urandom_range(1, a_per - 1), b_per, $urandom_range(1, b_per - 1),
                   $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            measure($urandom_range(2, S + W + 1), $urandom_range(2, S + W + 1));
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        bad++;
        $display("FAIL watchdog: got no end of test want end before 600000 time units");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ro_pair_counter.md
Name: ro_pair_counter

Overview:
- Downstream consumer of two ring-oscillator outputs in the delay-based PUF.
- Per challenge it:
  - enables one selected pair of ring oscillators;
  - lets them settle;
  - counts rising edges of each over a fixed window of system clocks;
  - produces one response bit from comparing the two counts.
- It drives the oscillators' enable inputs and sits between the RO array/mux and the response shift/collection logic.

Parameters:
- CNT_W, 16, width of each edge counter and count outputs.
- WINDOW, 1024, number of clk cycles in the counting window (>=1).
- SETTLE_CYC, 16, clk cycles between enabling the ROs and opening the window (>=1).
- SYNC_STAGES, 2, flip-flops in each asynchronous RO synchronizer (>=2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin one measurement; sampled only in IDLE.
- ro_a  input  1  oscillator A output, asynchronous to clk.
- ro_b  input  1  oscillator B output, asynchronous to clk.
- en_a  output  1  enable to oscillator A.
- en_b  output  1  enable to oscillator B.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; result valid.
- response  output  1  1 when count_a > count_b.
- tie  output  1  1 when count_a == count_b.
- count_a  output  CNT_W  edges counted on ro_a in the last window.
- count_b  output  CNT_W  edges counted on ro_b in the last window.

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE;
  - en_a/en_b/busy/done/response/tie = 0;
  - count_a/count_b = 0;
  - synchronizer and edge-history flops = 0.
- Deassertion of rst_n is used as-is; the upstream reset synchronizer owns release timing.
- FSM states: IDLE, SETTLE, COUNT, DONE.
- IDLE:
  - start=1 -> SETTLE.
  - Timer loads SETTLE_CYC-1.
  - Both counters clear to 0.
  - en_a/en_b assert the next cycle.
- SETTLE:
  - en_a=en_b=1, busy=1.
  - Edges are not counted.
  - Timer=0 -> COUNT, timer loads WINDOW-1.
- COUNT:
  - en_a=en_b=1, busy=1.
  - Each counter increments by 1 in every cycle where its synchronized input shows a rising edge (sync_now=1 and sync_prev=0).
  - Counters saturate at 2^CNT_W-1; they never wrap.
  - Timer=0 -> DONE; the edge detected in that final cycle is still counted.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - en_a=en_b deassert.
  - response=(count_a>count_b), tie=(count_a==count_b); on a tie, response=0.
  - Next state IDLE.
- Timing:
  - done asserts exactly 1+SETTLE_CYC+WINDOW cycles after the cycle in which start was sampled high.
  - count_a/count_b/response/tie hold their values until the next accepted start. The counters clear in the cycle after that start.
- start while not IDLE is ignored; there is no queuing.
- start held high continuously produces back-to-back measurements separated by one IDLE cycle.
- Synchronizers run continuously. The edge-detect history is updated in every state, so edges caused by the enable turning on fall in SETTLE and are never counted.
- Both counters are evaluated in the same cycle, so simultaneous edges on ro_a and ro_b increment both.
- Reset mid-measurement: immediate return to IDLE with all outputs at reset values; no done pulse.
- Measurement is valid only when the RO frequency is below clk/2 after any external prescaling; this is not checked.

Decomposition:
- Package puf_pkg:
  - typedef enum ro_cnt_state_t {IDLE, SETTLE, COUNT, DONE};
  - default localparams for CNT_W/WINDOW/SETTLE_CYC, shared by the response-collection logic.
- Sub-module ro_edge_sync:
  - parameter SYNC_STAGES;
  - ports clk, rst_n, async_in, rise_pulse;
  - contains the SYNC_STAGES flop chain plus one history flop;
  - instantiated twice, for ro_a and ro_b.
- Top level holds the FSM, the shared timer ($clog2 of max(WINDOW,SETTLE_CYC) bits) and the two saturating counters.

Test Plan:
- Basic compare:
  - Stimulus: WINDOW=96, SETTLE_CYC=4; ro_a period 8 clk, ro_b period 12 clk; pulse start.
  - Required: count_a=12, count_b=8, response=1, tie=0; done exactly 101 cycles after start sampled.
- Swap/tie:
  - Stimulus: same setup with ro_a period 12 and ro_b period 8.
  - Required: response=0, tie=0.
  - Stimulus: both at period 8.
  - Required: count_a=count_b=12, tie=1, response=0.
- Saturation:
  - Stimulus: CNT_W=3, WINDOW=96, ro_a period 4.
  - Required: count_a=7 (not wrapped to 0), count_b per its stimulus.
- Enables/ignored start:
  - Required: en_a/en_b high exactly SETTLE_CYC+WINDOW cycles and low in DONE.
  - Stimulus: start pulses during SETTLE and during COUNT.
  - Required: no restart, single done.
- Async reset mid-COUNT:
  - Stimulus: rst_n=0 for 3 cycles during COUNT.
  - Required: outputs read 0 within the reset cycle without a clock edge, no done.
  - Stimulus: fresh start after reset.
  - Required: the fresh start completes with correct counts.
- Continuous start:
  - Stimulus: start held high.
  - Required: done pulses every 2+SETTLE_CYC+WINDOW cycles, with identical counts for static stimulus.
